// File: rtl/decode_stage.sv
// Registered instruction-decode stage: splits an instruction word into opcode, address, type and
// register fields behind valid/ready handshakes, with a 2-entry skid buffer for full throughput.
module decode_stage #(
  parameter int unsigned OPCODE_WIDTH      = 6,
  parameter int unsigned ADDRESS_WIDTH     = 8,
  parameter int unsigned REGISTER_BITS     = 3,
  parameter int unsigned INSTRUCTION_WIDTH = 40
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OPCODE_WIDTH-1:0]      opCode,
  output logic [ADDRESS_WIDTH-1:0]     address1In,
  output logic [ADDRESS_WIDTH-1:0]     address2In,
  output logic [ADDRESS_WIDTH-1:0]     addressOut,
  output logic [1:0]                   address1Type,
  output logic [1:0]                   address2Type,
  output logic [1:0]                   outType,
  output logic [REGISTER_BITS-1:0]     register1In,
  output logic [REGISTER_BITS-1:0]     register2In,
  output logic [REGISTER_BITS-1:0]     registerOut,
  output logic [2:0]                   registerHasAddress,
  output logic [ADDRESS_WIDTH-1:0]     instructionValue,
  output logic                         illegal
);

  localparam int OW    = OPCODE_WIDTH;
  localparam int AW    = ADDRESS_WIDTH;
  localparam int W     = INSTRUCTION_WIDTH;
  localparam int OpLo  = W - 2 - OW;
  localparam int A1Lo  = OpLo - AW;
  localparam int A2Lo  = A1Lo - AW;
  localparam int AoLo  = A2Lo - AW;

  if (INSTRUCTION_WIDTH < 2 + OPCODE_WIDTH + 3 * ADDRESS_WIDTH + 7) begin : g_width_check
    $error("decode_stage: INSTRUCTION_WIDTH too small for the field layout");
  end
  if (REGISTER_BITS > ADDRESS_WIDTH) begin : g_reg_check
    $error("decode_stage: REGISTER_BITS must not exceed ADDRESS_WIDTH");
  end

  typedef struct packed {
    logic          has1;
    logic          has2;
    logic          has_out;
    logic [OW-1:0] op;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [AW-1:0] ao;
    logic [1:0]    t1;
    logic [1:0]    t2;
    logic [1:0]    to;
    logic          ill;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t dec;
  logic   push;
  logic   pop;

  // Padding bits between addressOut and bit 6 carry no meaning; fold them here to keep lint quiet.
  logic   unused_bits;
  assign unused_bits = ^instruction;

  always_comb begin
    dec         = '0;
    dec.has1    = instruction[W-1];
    dec.has2    = instruction[W-2];
    dec.op      = instruction[OpLo +: OW];
    dec.a1      = instruction[A1Lo +: AW];
    dec.a2      = instruction[A2Lo +: AW];
    dec.ao      = instruction[AoLo +: AW];
    dec.has_out = instruction[6];
    dec.t1      = instruction[5:4];
    dec.t2      = instruction[3:2];
    dec.to      = instruction[1:0];
    dec.ill     = (&instruction[5:4]) | (&instruction[3:2]) | (&instruction[1:0]);
  end

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (push) begin
          main_d  = dec;
          state_d = StOne;
        end
      end
      StOne: begin
        if (push && pop) begin
          main_d = dec;
        end else if (push) begin
          skid_d  = dec;
          state_d = StTwo;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Handshake flags are registered from the next state so neither depends on out_ready directly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StEmpty;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d != StTwo);
      out_valid <= (state_d != StEmpty);
      main_q    <= main_d;
      skid_q    <= skid_d;
    end
  end

  assign opCode             = main_q.op;
  assign address1In         = main_q.a1;
  assign address2In         = main_q.a2;
  assign addressOut         = main_q.ao;
  assign address1Type       = main_q.t1;
  assign address2Type       = main_q.t2;
  assign outType            = main_q.to;
  assign register1In        = main_q.a1[REGISTER_BITS-1:0];
  assign register2In        = main_q.a2[REGISTER_BITS-1:0];
  assign registerOut        = main_q.ao[REGISTER_BITS-1:0];
  assign registerHasAddress = {main_q.has1, main_q.has2, main_q.has_out};
  assign instructionValue   = main_q.a2;
  assign illegal            = main_q.ill;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic against a
// queue-based reference model that decodes fields by shift-and-mask arithmetic.
module tb_decode_stage;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Default-parameter DUT
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [39:0] instruction = '0;
  logic [5:0]  opCode;
  logic [7:0]  address1In, address2In, addressOut, instructionValue;
  logic [1:0]  address1Type, address2Type, outType;
  logic [2:0]  register1In, register2In, registerOut, registerHasAddress;
  logic        illegal;

  // Wider-parameter DUT
  logic        p_in_valid = 1'b0, p_in_ready, p_out_valid, p_out_ready = 1'b1;
  logic [45:0] p_instruction = '0;
  logic [6:0]  p_opCode;
  logic [9:0]  p_address1In, p_address2In, p_addressOut, p_instructionValue;
  logic [1:0]  p_address1Type, p_address2Type, p_outType;
  logic [2:0]  p_register1In, p_register2In, p_registerOut, p_registerHasAddress;
  logic        p_illegal;

  decode_stage dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .opCode(opCode), .address1In(address1In), .address2In(address2In),
    .addressOut(addressOut), .address1Type(address1Type), .address2Type(address2Type),
    .outType(outType), .register1In(register1In), .register2In(register2In),
    .registerOut(registerOut), .registerHasAddress(registerHasAddress),
    .instructionValue(instructionValue), .illegal(illegal)
  );

  decode_stage #(
    .OPCODE_WIDTH(7), .ADDRESS_WIDTH(10), .REGISTER_BITS(3), .INSTRUCTION_WIDTH(46)
  ) dut_p (
    .clock(clock), .reset(reset), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .instruction(p_instruction), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .opCode(p_opCode), .address1In(p_address1In), .address2In(p_address2In),
    .addressOut(p_addressOut), .address1Type(p_address1Type), .address2Type(p_address2Type),
    .outType(p_outType), .register1In(p_register1In), .register2In(p_register2In),
    .registerOut(p_registerOut), .registerHasAddress(p_registerHasAddress),
    .instructionValue(p_instructionValue), .illegal(p_illegal)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [39:0] q[$];

  typedef struct {
    longint unsigned op, a1, a2, ao, t1, t2, to, r1, r2, ro, has, imm, ill;
  } exp_t;

  function automatic longint unsigned fld(longint unsigned w, int lo, int n);
    return (w >> lo) & ((64'd1 << n) - 64'd1);
  endfunction

  function automatic exp_t model(longint unsigned w, int iw, int ow, int aw, int rb);
    exp_t e;
    int   op_lo;
    op_lo = iw - 2 - ow;
    e.op  = fld(w, op_lo, ow);
    e.a1  = fld(w, op_lo - aw, aw);
    e.a2  = fld(w, op_lo - 2 * aw, aw);
    e.ao  = fld(w, op_lo - 3 * aw, aw);
    e.t1  = fld(w, 4, 2);
    e.t2  = fld(w, 2, 2);
    e.to  = fld(w, 0, 2);
    e.r1  = e.a1 % (64'd1 << rb);
    e.r2  = e.a2 % (64'd1 << rb);
    e.ro  = e.ao % (64'd1 << rb);
    e.has = fld(w, iw - 1, 1) * 4 + fld(w, iw - 2, 1) * 2 + fld(w, 6, 1);
    e.imm = e.a2;
    e.ill = (e.t1 == 3 || e.t2 == 3 || e.to == 3) ? 1 : 0;
    return e;
  endfunction

  function automatic logic [56:0] exp_main(logic [39:0] w);
    exp_t e;
    e = model(64'(w), 40, 6, 8, 3);
    return {6'(e.op), 8'(e.a1), 8'(e.a2), 8'(e.ao), 2'(e.t1), 2'(e.t2), 2'(e.to),
            3'(e.r1), 3'(e.r2), 3'(e.ro), 3'(e.has), 8'(e.imm), 1'(e.ill)};
  endfunction

  function automatic logic [56:0] obs_main();
    return {opCode, address1In, address2In, addressOut, address1Type, address2Type, outType,
            register1In, register2In, registerOut, registerHasAddress, instructionValue, illegal};
  endfunction

  function automatic logic [65:0] exp_p(logic [45:0] w);
    exp_t e;
    e = model(64'(w), 46, 7, 10, 3);
    return {7'(e.op), 10'(e.a1), 10'(e.a2), 10'(e.ao), 2'(e.t1), 2'(e.t2), 2'(e.to),
            3'(e.r1), 3'(e.r2), 3'(e.ro), 3'(e.has), 10'(e.imm), 1'(e.ill)};
  endfunction

  function automatic logic [65:0] obs_p();
    return {p_opCode, p_address1In, p_address2In, p_addressOut, p_address1Type,
            p_address2Type, p_outType, p_register1In, p_register2In, p_registerOut,
            p_registerHasAddress, p_instructionValue, p_illegal};
  endfunction

  // One clock of the default DUT; the model queue follows the transfers that edge makes.
  task automatic cycle();
    bit          pop, push;
    logic [39:0] w;
    pop  = (q.size() > 0) && out_ready;
    push = in_valid && (q.size() < 2);
    w    = instruction;
    @(posedge clock);
    #1;
    if (reset) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(w);
    end
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if (in_ready !== 1'b0) begin
      $display("FAIL reset_in_ready got=%b want=0", in_ready); n_err++;
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid got=%b want=0", out_valid); n_err++;
    end
    n_vec++;
    if (obs_main() !== 57'd0) begin
      $display("FAIL reset_fields got=%h want=0", obs_main()); n_err++;
    end
    n_vec++;
    if (obs_p() !== 66'd0) begin
      $display("FAIL reset_fields_p got=%h want=0", obs_p()); n_err++;
    end
    @(negedge clock);
    reset = 1'b0;
    q.delete();
    cycle();
    n_vec++;
    if (in_ready !== 1'b1) begin
      $display("FAIL release_in_ready got=%b want=1", in_ready); n_err++;
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      $display("FAIL release_out_valid got=%b want=0", out_valid); n_err++;
    end
  endtask

  task automatic test_decode();
    logic [56:0] want;
    want = {6'd1, 8'h0A, 8'h0B, 8'h0C, 2'd1, 2'd2, 2'd1, 3'd2, 3'd3, 3'd4, 3'b111, 8'h0B, 1'b0};
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    instruction = 40'hC1_0A_0B_0C_59;
    cycle();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1) begin
      $display("FAIL decode_valid got=%b want=1", out_valid); n_err++;
    end
    n_vec++;
    if (obs_main() !== want) begin
      $display("FAIL decode_fields got=%h want=%h", obs_main(), want); n_err++;
    end
    n_vec++;
    if (obs_main() !== exp_main(instruction)) begin
      $display("FAIL decode_model got=%h want=%h", obs_main(), exp_main(instruction)); n_err++;
    end
    cycle();
    n_vec++;
    if (out_valid !== 1'b0) begin
      $display("FAIL decode_drain got=%b want=0", out_valid); n_err++;
    end
  endtask

  task automatic test_illegal();
    in_valid    = 1'b1;
    instruction = 40'hC1_0A_0B_0C_5B;
    cycle();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 || outType !== 2'd3) begin
      $display("FAIL illegal_flag got v=%b ill=%b ot=%0d want v=1 ill=1 ot=3",
               out_valid, illegal, outType);
      n_err++;
    end
    n_vec++;
    if (obs_main() !== exp_main(instruction)) begin
      $display("FAIL illegal_fields got=%h want=%h", obs_main(), exp_main(instruction)); n_err++;
    end
    cycle();
  endtask

  task automatic test_stream();
    logic [39:0] words[8];
    for (int i = 0; i < 8; i++) words[i] = 40'({$urandom(), $urandom()});
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      instruction = words[i];
      cycle();
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
        $display("FAIL stream_hs[%0d] got v=%b r=%b want v=1 r=1", i, out_valid, in_ready);
        n_err++;
      end
      n_vec++;
      if (obs_main() !== exp_main(words[i])) begin
        $display("FAIL stream_data[%0d] got=%h want=%h", i, obs_main(), exp_main(words[i]));
        n_err++;
      end
    end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_backpressure();
    logic [39:0] w[3];
    logic        r_want[6];
    int          o_want[6];
    for (int i = 0; i < 3; i++) w[i] = 40'({$urandom(), $urandom()});
    // Per-cycle expectations: in_ready and which word sits at the output.
    r_want = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    o_want = '{0, 0, 0, 1, 2, -1};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      instruction = (c == 0) ? w[0] : (c == 1) ? w[1] : w[2];
      if (c == 3) out_ready = 1'b1;
      if (c == 5) in_valid = 1'b0;
      cycle();
      n_vec++;
      if (in_ready !== r_want[c]) begin
        $display("FAIL bp_in_ready[%0d] got=%b want=%b", c, in_ready, r_want[c]); n_err++;
      end
      n_vec++;
      if (o_want[c] < 0) begin
        if (out_valid !== 1'b0) begin
          $display("FAIL bp_drain got=%b want=0", out_valid); n_err++;
        end
      end else if (out_valid !== 1'b1 || obs_main() !== exp_main(w[o_want[c]])) begin
        $display("FAIL bp_data[%0d] got v=%b d=%h want v=1 d=%h", c, out_valid, obs_main(),
                 exp_main(w[o_want[c]]));
        n_err++;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      instruction = 40'({$urandom(), $urandom()});
      cycle();
      n_vec++;
      if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0)) begin
        $display("FAIL rand_hs[%0d] got r=%b v=%b want r=%b v=%b", i, in_ready, out_valid,
                 q.size() < 2, q.size() > 0);
        n_err++;
      end
      if (q.size() > 0) begin
        n_vec++;
        if (obs_main() !== exp_main(q[0])) begin
          $display("FAIL rand_data[%0d] got=%h want=%h", i, obs_main(), exp_main(q[0]));
          n_err++;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
  endtask

  task automatic test_params();
    logic [45:0] w;
    p_out_ready = 1'b1;
    for (int i = 0; i < 46; i++) begin
      w             = 46'(64'd1 << i);
      p_instruction = w;
      p_in_valid    = 1'b1;
      @(posedge clock);
      #1;
      n_vec++;
      if (p_out_valid !== 1'b1 || obs_p() !== exp_p(w)) begin
        $display("FAIL param_bit[%0d] got v=%b d=%h want v=1 d=%h", i, p_out_valid, obs_p(),
                 exp_p(w));
        n_err++;
      end
    end
    p_in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instruction = 40'hFF_12_34_56_7F;
    cycle();
    instruction = 40'h3F_AB_CD_EF_40;
    cycle();
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0 || q.size() != 2) begin
      $display("FAIL rst_fill got r=%b want r=0", in_ready); n_err++;
    end
    #3;
    reset = 1'b1;
    #1;
    q.delete();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || obs_main() !== 57'd0) begin
      $display("FAIL rst_async got v=%b r=%b d=%h want v=0 r=0 d=0", out_valid, in_ready,
               obs_main());
      n_err++;
    end
    @(posedge clock);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    cycle();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL rst_release got r=%b v=%b want r=1 v=0", in_ready, out_valid); n_err++;
    end
    cycle();
    n_vec++;
    if (out_valid !== 1'b0 || obs_main() !== 57'd0) begin
      $display("FAIL rst_stale got v=%b d=%h want v=0 d=0", out_valid, obs_main()); n_err++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_decode();
    test_illegal();
    test_stream();
    test_backpressure();
    test_random();
    test_params();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
